// File: rtl/saw_note_sched.sv
// Monophonic last-note-priority scheduler feeding the sawtooth generator's target frequency and pause.
// Optional build macro SAW_GLIDE_EN enables per-pulse frequency slew by GLIDE_STEP.
module saw_note_sched #(
    parameter int          NREQ       = 2,
    parameter int          DEPTH      = 8,
    parameter logic [23:0] GLIDE_STEP = 24'd4
) (
    input  logic              i_clk48,
    input  logic              i_rst48,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ-1:0]   i_req_on,
    input  logic [24*NREQ-1:0] i_req_freq,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic              i_pulse,
    output logic [23:0]       o_targetf,
    output logic              o_pause,
    output logic [4:0]        o_held,
    output logic              o_overflow,
    input  logic              i_clr_ovf
);

    localparam int         IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    // Without glide an all-ones step makes every slew snap, i.e. a direct load.
`ifdef SAW_GLIDE_EN
    localparam logic [23:0] STEP = GLIDE_STEP;
`else
    localparam logic [23:0] STEP = GLIDE_STEP | 24'hFFFFFF;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, PUSH} state_t;

    state_t          state, state_next;
    logic [23:0]     stack [DEPTH];
    logic [4:0]      idx, idx_next, idx_p1, top_idx;
    logic [5:0]      idx_p2;
    logic            ev_on;
    logic [23:0]     ev_freq;
    logic [IW-1:0]   start_ptr, grant_idx;
    logic [NREQ-1:0] grant;
    logic            found, sel_on;
    logic [23:0]     sel_freq;
    logic            load_ev, push_en, copy_en, dec_en, set_ovf;
    logic [23:0]     next_f, up_diff, down_diff;
    logic            next_pause;
    int              cand;

    // Round-robin search from start_ptr; ready is offered only while idle and out of reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel_on    = 1'b0;
        sel_freq  = '0;
        cand      = 0;
        for (int o = 0; o < NREQ; o++) begin
            cand = int'(start_ptr) + o;
            if (cand >= NREQ)
                cand = cand - NREQ;
            if (!found && i_req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = IW'(cand);
            end
        end
        if (state != IDLE || i_rst48)
            found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (found && grant_idx == IW'(k)) begin
                grant[k] = 1'b1;
                sel_on   = i_req_on[k];
                sel_freq = i_req_freq[24*k +: 24];
            end
        end
    end

    assign o_req_ready = grant;
    assign idx_p1      = idx + 5'd1;
    assign idx_p2      = {1'b0, idx} + 6'd2;
    assign top_idx     = o_held - 5'd1;

    always_ff @(posedge i_clk48 or posedge i_rst48) begin
        if (i_rst48)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load_ev    = 1'b0;
        push_en    = 1'b0;
        copy_en    = 1'b0;
        dec_en     = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load_ev = 1'b1;
                    if (sel_freq == 24'd0)
                        state_next = IDLE;
                    else if (o_held == 5'd0)
                        state_next = sel_on ? PUSH : IDLE;
                    else begin
                        state_next = SCAN;
                        idx_next   = top_idx;
                    end
                end
            end
            SCAN: begin
                if (stack[idx[SW-1:0]] == ev_freq)
                    state_next = SHIFT;
                else if (idx == 5'd0) begin
                    if (!ev_on)
                        state_next = IDLE;
                    else if (o_held == DEPTH_L) begin
                        // Full stack: drop the oldest note to make room.
                        state_next = SHIFT;
                        set_ovf    = 1'b1;
                    end else
                        state_next = PUSH;
                end else
                    idx_next = idx - 5'd1;
            end
            SHIFT: begin
                copy_en = (idx_p1 < o_held);
                if (idx_p2 >= {1'b0, o_held}) begin
                    dec_en     = 1'b1;
                    state_next = ev_on ? PUSH : IDLE;
                end else
                    idx_next = idx_p1;
            end
            PUSH: begin
                push_en    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk48 or posedge i_rst48) begin
        if (i_rst48) begin
            for (int i = 0; i < DEPTH; i++)
                stack[i] <= '0;
            o_held     <= '0;
            idx        <= '0;
            ev_on      <= 1'b0;
            ev_freq    <= '0;
            start_ptr  <= '0;
            o_overflow <= 1'b0;
        end else begin
            idx <= idx_next;
            if (load_ev) begin
                ev_on     <= sel_on;
                ev_freq   <= sel_freq;
                start_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (copy_en)
                stack[idx[SW-1:0]] <= stack[idx_p1[SW-1:0]];
            if (dec_en)
                o_held <= o_held - 5'd1;
            if (push_en) begin
                stack[o_held[SW-1:0]] <= ev_freq;
                o_held                <= o_held + 5'd1;
            end
            if (set_ovf)
                o_overflow <= 1'b1;
            else if (i_clr_ovf)
                o_overflow <= 1'b0;
        end
    end

    assign next_f     = (o_held == 5'd0) ? o_targetf : stack[top_idx[SW-1:0]];
    assign next_pause = (o_held == 5'd0);
    assign up_diff    = next_f - o_targetf;
    assign down_diff  = o_targetf - next_f;

    // Outputs move only on the sample pulse; a note starting from pause jumps without slewing.
    always_ff @(posedge i_clk48 or posedge i_rst48) begin
        if (i_rst48) begin
            o_targetf <= '0;
            o_pause   <= 1'b1;
        end else if (i_pulse) begin
            o_pause <= next_pause;
            if (!next_pause) begin
                if (o_pause)
                    o_targetf <= next_f;
                else if (next_f >= o_targetf)
                    o_targetf <= (up_diff <= STEP) ? next_f : o_targetf + STEP;
                else
                    o_targetf <= (down_diff <= STEP) ? next_f : o_targetf - STEP;
            end
        end
    end

endmodule
